regread_fwd_stage: RTL and testbench



---
 rtl/regread_fwd_stage_pkg.sv | 26 ++
 rtl/regread_fwd_stage_pend_scoreboard.sv | 63 ++++++
 rtl/regread_fwd_stage.sv | 135 +++++++++++++
 tb/tb_regread_fwd_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regread_fwd_stage_pkg.sv
// Shared definitions for the register-read / forwarding stage.
//   - default widths for data, register address, forwarding ports, counters
//   - operand slot indices (rn, rm, rd) used to pack per-source arrays
//   - forwarding priority: port 0 is the youngest in-flight writer and wins
//   - pend_max(): largest count a CNT_W-bit scoreboard counter can hold
package regread_fwd_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 4;
  localparam int NUM_FWD_DEF = 2;
  localparam int CNT_W_DEF   = 2;

  // Operand slots; rd is read as a source too (e.g. store data, MLA acc).
  localparam int OP_RN   = 0;
  localparam int OP_RM   = 1;
  localparam int OP_RD   = 2;
  localparam int NUM_OPS = 3;

  // Lowest forwarding index = youngest producer = highest priority.
  localparam int FWD_YOUNGEST = 0;

  function automatic int pend_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/regread_fwd_stage_pend_scoreboard.sv
// pend_scoreboard: per-register count of issued-but-not-retired writers.
// Ports:
//   clk, reset      clock, synchronous active-high reset (clears all counts)
//   inc_en, inc_a   one issued writer to inc_a
//   dec_en, dec_a   one writer to dec_a retiring (squashed or not)
//   rd_a            NUM_OPS read addresses
//   eff_pend        per read address: count minus a same-cycle retire of it
module pend_scoreboard
  import regread_fwd_stage_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inc_en,
  input  logic [REG_AW-1:0]                inc_a,
  input  logic                             dec_en,
  input  logic [REG_AW-1:0]                dec_a,
  input  logic [NUM_OPS-1:0][REG_AW-1:0]   rd_a,
  output logic [NUM_OPS-1:0][CNT_W-1:0]    eff_pend
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0][CNT_W-1:0] pend;
  logic [NREG-1:0]            inc_vec, dec_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[inc_a] = 1'b1;
    if (dec_en) dec_vec[dec_a] = 1'b1;
  end

  // inc+dec on the same register cancel; a stray retire at 0 is held at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          pend[r] <= pend[r] + 1'b1;
        else if (!inc_vec[r] && dec_vec[r] && pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  // Depends only on state and the retire port, never on inc, so the
  // accept -> inc path in the parent stays loop-free.
  always_comb begin
    for (int s = 0; s < NUM_OPS; s++) begin
      eff_pend[s] = pend[rd_a[s]];
      if (dec_en && dec_a == rd_a[s] && pend[rd_a[s]] != '0)
        eff_pend[s] = pend[rd_a[s]] - 1'b1;
    end
  end

  a_no_retire_at_zero : assert property (@(posedge clk) disable iff (reset)
    !(dec_en && pend[dec_a] == '0));

endmodule

// File: rtl/regread_fwd_stage.sv
// regread_fwd_stage: register-read stage between decode and execute.
// Holds the architectural register file, a pending-writer scoreboard and a
// NUM_FWD-port forwarding mux; stalls decode (in_ready) on unresolved
// operands or scoreboard saturation and emits bubbles downstream.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        decode handshake (in_ready is combinational)
//   rn_a, rm_a, rd_a, uses_*   source addresses and their read enables
//   dest_we                    instruction writes rd_a
//   flush, stall_in            kill / downstream hold
//   fwd_busy/valid/a/d         in-flight writers, port 0 youngest
//   ret_valid/we/a/d           retire port (writes register file)
//   out_valid, rn_d, rm_d, rd_d, out_rd_a, out_dest_we   output register
module regread_fwd_stage
  import regread_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_AW-1:0]         rn_a,
  input  logic [REG_AW-1:0]         rm_a,
  input  logic [REG_AW-1:0]         rd_a,
  input  logic                      uses_rn,
  input  logic                      uses_rm,
  input  logic                      uses_rd,
  input  logic                      dest_we,
  input  logic                      flush,
  input  logic                      stall_in,
  input  logic [NUM_FWD-1:0]        fwd_busy,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_a,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_d,
  input  logic                      ret_valid,
  input  logic                      ret_we,
  input  logic [REG_AW-1:0]         ret_a,
  input  logic [DATA_W-1:0]         ret_d,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         rn_d,
  output logic [DATA_W-1:0]         rm_d,
  output logic [DATA_W-1:0]         rd_d,
  output logic [REG_AW-1:0]         out_rd_a,
  output logic                      out_dest_we
);

  localparam int NREG = 2 ** REG_AW;
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));

  logic [NREG-1:0][DATA_W-1:0]         rf;
  logic [NUM_FWD-1:0][REG_AW-1:0]      fa;
  logic [NUM_FWD-1:0][DATA_W-1:0]      fd;
  logic [NUM_OPS-1:0][REG_AW-1:0]      src_a;
  logic [NUM_OPS-1:0]                  src_use;
  logic [NUM_OPS-1:0][CNT_W-1:0]       eff_pend;
  logic [NUM_OPS-1:0][DATA_W-1:0]      opd;
  logic [NUM_OPS-1:0]                  src_haz;
  logic                                sat_haz, hazard, accept, rf_wr;

  assign fa      = fwd_a;
  assign fd      = fwd_d;
  assign src_a   = {rd_a, rm_a, rn_a};
  assign src_use = {uses_rd, uses_rm, uses_rn};
  assign rf_wr   = ret_valid & ret_we;

  always_ff @(posedge clk) begin
    if (reset)      rf <= '0;
    else if (rf_wr) rf[ret_a] <= ret_d;
  end

  pend_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (accept & dest_we),
    .inc_a    (rd_a),
    .dec_en   (ret_valid),
    .dec_a    (ret_a),
    .rd_a     (src_a),
    .eff_pend (eff_pend)
  );

  // Per source: youngest matching writer wins; if it is not ready yet the
  // source stalls even when an older port already holds a value.
  always_comb begin
    for (int s = 0; s < NUM_OPS; s++) begin
      logic              found, hit_vld;
      logic [DATA_W-1:0] hit_d, rf_val;
      found   = 1'b0;
      hit_vld = 1'b0;
      hit_d   = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && fwd_busy[i] && fa[i] == src_a[s]) begin
          found   = 1'b1;
          hit_vld = fwd_valid[i];
          hit_d   = fd[i];
        end
      end
      rf_val     = (rf_wr && ret_a == src_a[s]) ? ret_d : rf[src_a[s]];
      opd[s]     = (src_use[s] && found) ? hit_d : rf_val;
      src_haz[s] = src_use[s] & (found ? ~hit_vld : (eff_pend[s] != '0));
    end
  end

  // eff_pend already credits a same-cycle retire of rd_a.
  assign sat_haz  = dest_we & (eff_pend[OP_RD] == PEND_MAX);
  assign hazard   = (|src_haz) | sat_haz;
  assign in_ready = ~reset & ~stall_in & ~flush & ~hazard;
  assign accept   = in_valid & in_ready;

  // Output register: reset and flush both clear it; stall holds everything.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid   <= 1'b0;
      rn_d        <= '0;
      rm_d        <= '0;
      rd_d        <= '0;
      out_rd_a    <= '0;
      out_dest_we <= 1'b0;
    end else if (!stall_in) begin
      out_valid <= accept;
      if (accept) begin
        rn_d        <= opd[OP_RN];
        rm_d        <= opd[OP_RM];
        rd_d        <= opd[OP_RD];
        out_rd_a    <= rd_a;
        out_dest_we <= dest_we;
      end
    end
  end

endmodule

// File: tb/tb_regread_fwd_stage.sv
// Directed bench for regread_fwd_stage with hand-computed expectations.
module tb_regread_fwd_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  rn_a, rm_a, rd_a;
  logic        uses_rn, uses_rm, uses_rd, dest_we, flush, stall_in;
  logic [1:0]  fwd_busy, fwd_valid;
  logic [7:0]  fwd_a;
  logic [63:0] fwd_d;
  logic        ret_valid, ret_we;
  logic [3:0]  ret_a;
  logic [31:0] ret_d;
  logic        out_valid;
  logic [31:0] rn_d, rm_d, rd_d;
  logic [3:0]  out_rd_a;
  logic        out_dest_we;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regread_fwd_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rn_a(rn_a), .rm_a(rm_a), .rd_a(rd_a),
    .uses_rn(uses_rn), .uses_rm(uses_rm), .uses_rd(uses_rd),
    .dest_we(dest_we), .flush(flush), .stall_in(stall_in),
    .fwd_busy(fwd_busy), .fwd_valid(fwd_valid), .fwd_a(fwd_a), .fwd_d(fwd_d),
    .ret_valid(ret_valid), .ret_we(ret_we), .ret_a(ret_a), .ret_d(ret_d),
    .out_valid(out_valid), .rn_d(rn_d), .rm_d(rm_d), .rd_d(rd_d),
    .out_rd_a(out_rd_a), .out_dest_we(out_dest_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rn_a = 0; rm_a = 0; rd_a = 0;
    uses_rn = 0; uses_rm = 0; uses_rd = 0; dest_we = 0;
    flush = 0; stall_in = 0;
    fwd_busy = 0; fwd_valid = 0; fwd_a = 0; fwd_d = 0;
    ret_valid = 0; ret_we = 0; ret_a = 0; ret_d = 0;
  endtask

  task automatic issue_dest(input logic [3:0] rd);
    idle();
    in_valid = 1; dest_we = 1; rd_a = rd;
  endtask

  task automatic read_rn(input logic [3:0] rn);
    idle();
    in_valid = 1; uses_rn = 1; rn_a = rn;
  endtask

  task automatic retire(input logic [3:0] a, input logic we, input logic [31:0] d);
    ret_valid = 1; ret_we = we; ret_a = a; ret_d = d;
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    in_valid = 1; #1;
    chk("rdy_in_reset", in_ready, 0);
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rn_d", rn_d, 0);
    chk("rst_out_rd_a", out_rd_a, 0);
    chk("rst_out_dest_we", out_dest_we, 0);
    reset = 0;
    idle();
    step();
    chk("post_rst_out_valid", out_valid, 0);

    // r1: issue a writer, retire it with 0x55, then read it back.
    issue_dest(1); #1;
    chk("r1_issue_rdy", in_ready, 1);
    step();
    chk("r1_issue_valid", out_valid, 1);
    chk("r1_issue_rd_a", out_rd_a, 1);
    chk("r1_issue_dest_we", out_dest_we, 1);
    idle(); retire(1, 1, 32'h55);
    step();
    chk("r1_bubble", out_valid, 0);
    read_rn(1); #1;
    chk("r1_read_rdy", in_ready, 1);
    step();
    chk("r1_read_valid", out_valid, 1);
    chk("r1_read_rn_d", rn_d, 32'h55);

    // r2: ADD writes r2; consumer waits on fwd port 0 then takes 0x1234.
    issue_dest(2);
    step();
    read_rn(2); fwd_busy = 2'b01; fwd_a = 8'h02; #1;
    chk("r2_fwd_wait_rdy", in_ready, 0);
    step();
    chk("r2_bubble", out_valid, 0);
    fwd_valid = 2'b01; fwd_d = 64'h1234; #1;
    chk("r2_fwd_rdy", in_ready, 1);
    step();
    chk("r2_valid", out_valid, 1);
    chk("r2_rn_d", rn_d, 32'h1234);
    idle(); retire(2, 1, 32'h1234);
    step();

    // r3: both ports hold r3; youngest (port 0) wins.
    idle(); in_valid = 1; uses_rm = 1; rm_a = 3;
    fwd_busy = 2'b11; fwd_valid = 2'b11; fwd_a = 8'h33;
    fwd_d = {32'hB, 32'hA}; #1;
    chk("r3_rdy", in_ready, 1);
    step();
    chk("r3_rm_d_port0", rm_d, 32'hA);
    fwd_busy = 2'b10; #1;
    step();
    chk("r3_rm_d_port1", rm_d, 32'hB);
    fwd_busy = 2'b11; fwd_valid = 2'b10; #1;
    chk("r3_young_not_ready", in_ready, 0);
    step();
    chk("r3_bubble", out_valid, 0);

    // r4: pend=1 retiring in the same cycle as the read -> bypass 0x99.
    issue_dest(4);
    step();
    read_rn(4); retire(4, 1, 32'h99); #1;
    chk("r4_rdy", in_ready, 1);
    step();
    chk("r4_rn_d", rn_d, 32'h99);
    read_rn(4); #1;
    chk("r4_pend_cleared", in_ready, 1);
    step();
    chk("r4_rf_value", rn_d, 32'h99);

    // r5: three writers saturate a 2-bit counter; fourth waits for retire.
    for (int k = 0; k < 3; k++) begin
      issue_dest(5); #1;
      chk("r5_issue_rdy", in_ready, 1);
      step();
    end
    issue_dest(5); #1;
    chk("r5_saturated", in_ready, 0);
    step();
    chk("r5_sat_bubble", out_valid, 0);
    read_rn(5); #1;
    chk("r5_read_pending", in_ready, 0);
    issue_dest(5); retire(5, 0, 32'h0); #1;
    chk("r5_retire_relief", in_ready, 1);
    step();
    chk("r5_fourth_valid", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      idle(); retire(5, 0, 32'h0);
      step();
    end

    // Downstream stall holds, then flush under stall kills the output.
    issue_dest(6);
    step();
    chk("r6_valid", out_valid, 1);
    issue_dest(7); stall_in = 1; #1;
    chk("stall_rdy", in_ready, 0);
    step();
    chk("stall_hold_valid", out_valid, 1);
    chk("stall_hold_rd_a", out_rd_a, 6);
    flush = 1; #1;
    chk("flush_rdy", in_ready, 0);
    step();
    chk("flush_out_valid", out_valid, 0);
    read_rn(7); #1;
    chk("flush_no_pend_inc", in_ready, 1);
    step();
    chk("post_flush_valid", out_valid, 1);
    idle(); retire(6, 1, 32'h66);
    step();
    chk("drain_bubble", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
